ticket_frame_reader: RTL and testbench
======================================

Name: ticket_frame_reader

Overview:
- Upstream stage of the stadium gate fan counter.
- Deserialises one ticket frame per fan from a turnstile scanner line and checks it for framing, parity and entry/exit sequence errors.
- Presents a qualified ticket to the counter as `ticketID`, `gate` and `mode`.
- Tracks which of the 32 ticket IDs are currently inside, so a ticket cannot enter twice or exit without having entered.

Parameters:
- BIT_CYCLES, 4, CLK cycles per serial bit period; legal range 1..255.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- frameStart  input  1  scanner pulse marking the start of a frame; only acted on in IDLE.
- serialIn  input  1  scanner data line; LSB first, then parity bit, then stop bit.
- gateIn  input  1  scanner location: 0 = home gate, 1 = away gate; latched on frame start.
- dirIn  input  1  turnstile direction: 1 = entry, 0 = exit; latched on frame start.
- ticketID  output  5  decoded ticket ID; held until the next frame result.
- gate  output  1  latched gateIn of the last frame.
- mode  output  1  latched dirIn of the last frame.
- valid  output  1  one-cycle pulse: ticketID, gate and mode are accepted.
- frameErr  output  1  one-cycle pulse: stop bit was 0.
- parityErr  output  1  one-cycle pulse: even-parity failure.
- seqErr  output  1  one-cycle pulse: entry of an ID already inside, or exit of an ID not inside.
- busy  output  1  high whenever the FSM is not in IDLE.
- rejCount  output  8  count of rejected frames; saturates at 255.

Behaviour:
- Reset (RST=1 at an edge):
  - state goes to IDLE and the occupancy bitmap used[31:0] clears to 0;
  - every output goes to 0: ticketID, gate, mode, valid, the three error pulses, busy, rejCount;
  - reset mid-frame aborts the frame with no result pulse.
- FSM states:
  - IDLE → DATA when frameStart=1 at edge E0. At E0: latch gateIn and dirIn, load the bit timer with BIT_CYCLES-1, set bit index 0.
  - DATA: on every edge where the timer is 0, sample serialIn into shift[idx], reload the timer and increment idx. After idx 4 is sampled, go to PARITY.
  - PARITY: on the next timer expiry, sample the parity bit and go to STOP.
  - STOP: on the next timer expiry, sample the stop bit, evaluate the frame, register the result and go to IDLE.
- Sample timing:
  - data bit k is sampled at edge E0+(k+1)*BIT_CYCLES;
  - parity is sampled at E0+6*BIT_CYCLES;
  - stop is sampled at E0+7*BIT_CYCLES.
  - The result pulse is high for exactly one cycle after the stop edge. Frame latency is 7*BIT_CYCLES cycles.
- frameStart is ignored while busy=1. A frameStart during the result-pulse cycle is accepted, because the FSM is already in IDLE.
- Evaluation at the stop edge. Exactly one of valid, frameErr, parityErr, seqErr pulses, with priority frameErr > parityErr > seqErr > valid:
  - frameErr: stop bit = 0.
  - parityErr: XOR of the 5 data bits and the parity bit is 1 (even parity is required).
  - seqErr: mode=1 with used[ID]=1, or mode=0 with used[ID]=0.
  - valid: otherwise. On valid, used[ID] is set for mode=1 and cleared for mode=0, in the same edge that raises valid.
- ticketID, gate and mode update at the stop edge for every frame, including rejected ones. The downstream counter acts only when valid=1.
- rejCount increments at the stop edge on any error and holds at 255.
- The bit timer is an 8-bit down counter. With BIT_CYCLES=1 it is permanently 0, so one bit is sampled per cycle.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, serialIn toggling, no frameStart → busy=0, every output 0, no pulses.
- Good entry, BIT_CYCLES=4:
  - stimulus: frameStart at E0, gateIn=0, dirIn=1; bits 0,1,1,0,1 (ID=0x16), parity 1, stop 1;
  - response: valid=1 for exactly one cycle after edge E0+28, ticketID=0x16, gate=0, mode=1, used[0x16]=1.
- Sequence check:
  - repeat entry of 0x16 → seqErr pulse, rejCount=1, valid stays 0;
  - then exit of 0x16 (dirIn=0, gateIn=1) → valid, gate=1, mode=0, used[0x16]=0;
  - a second exit of 0x16 → seqErr, rejCount=2.
- Error priority: ID=0x03 with parity bit 1 → parityErr. Same frame with stop bit 0 → frameErr only, not parityErr.
- Busy and back-to-back:
  - frameStart pulses mid-frame are ignored, frame timing unchanged;
  - frameStart in the result cycle starts the next frame, whose result arrives 28 cycles later.
- Reset and saturation:
  - RST asserted at E0+12 → no result pulse; busy=0 and used cleared at the next edge;
  - 260 parity-error frames → rejCount=255.

Source files
------------

// File: rtl/ticket_frame_reader_if.sv
// Scanner-to-counter bundle for the ticket frame reader: scanner line inputs
// and qualified ticket results with their one-cycle status pulses.
interface ticket_frame_reader_if;
  logic       frameStart;
  logic       serialIn;
  logic       gateIn;
  logic       dirIn;
  logic [4:0] ticketID;
  logic       gate;
  logic       mode;
  logic       valid;
  logic       frameErr;
  logic       parityErr;
  logic       seqErr;
  logic       busy;
  logic [7:0] rejCount;

  modport master (
    output frameStart, serialIn, gateIn, dirIn,
    input  ticketID, gate, mode, valid, frameErr, parityErr, seqErr, busy, rejCount
  );

  modport slave (
    input  frameStart, serialIn, gateIn, dirIn,
    output ticketID, gate, mode, valid, frameErr, parityErr, seqErr, busy, rejCount
  );
endinterface

// File: rtl/ticket_frame_reader.sv
// Deserialises one turnstile ticket frame (5 data, even parity, stop), checks
// framing/parity/entry-exit sequence and tracks occupancy of the 32 ticket IDs.
module ticket_frame_reader #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input logic                  CLK,
  input logic                  RST,
  ticket_frame_reader_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [7:0] RELOAD = 8'(BIT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  timer;
  logic [2:0]  idx;
  logic [4:0]  shift;
  logic        par_bit;
  logic        cur_gate;
  logic        cur_dir;
  logic [31:0] used;

  logic [4:0]  ticket_id;
  logic        gate_q;
  logic        mode_q;
  logic        valid_q;
  logic        frame_err;
  logic        parity_err;
  logic        seq_err;
  logic [7:0]  rej_count;

  logic tick;
  logic par_fail;
  logic seq_fail;

  always_comb begin
    tick     = (timer == '0);
    par_fail = ^{shift, par_bit};
    // entry needs the ID outside, exit needs it inside
    seq_fail = cur_dir ? used[shift] : ~used[shift];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      cur_gate   <= 1'b0;
      cur_dir    <= 1'b0;
      used       <= '0;
      ticket_id  <= '0;
      gate_q     <= 1'b0;
      mode_q     <= 1'b0;
      valid_q    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      seq_err    <= 1'b0;
      rej_count  <= '0;
    end else begin
      valid_q    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      seq_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.frameStart) begin
            cur_gate <= bus.gateIn;
            cur_dir  <= bus.dirIn;
            timer    <= RELOAD;
            idx      <= '0;
            state    <= DATA;
          end
        end

        DATA: begin
          if (tick) begin
            shift[idx] <= bus.serialIn;
            timer      <= RELOAD;
            idx        <= idx + 3'd1;
            if (idx == 3'd4) state <= PARITY;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        PARITY: begin
          if (tick) begin
            par_bit <= bus.serialIn;
            timer   <= RELOAD;
            state   <= STOP;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        STOP: begin
          if (tick) begin
            state     <= IDLE;
            ticket_id <= shift;
            gate_q    <= cur_gate;
            mode_q    <= cur_dir;
            if (!bus.serialIn) begin
              frame_err <= 1'b1;
            end else if (par_fail) begin
              parity_err <= 1'b1;
            end else if (seq_fail) begin
              seq_err <= 1'b1;
            end else begin
              valid_q     <= 1'b1;
              used[shift] <= cur_dir;
            end
            if ((!bus.serialIn || par_fail || seq_fail) && rej_count != 8'hFF)
              rej_count <= rej_count + 8'd1;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ticketID  = ticket_id;
  assign bus.gate      = gate_q;
  assign bus.mode      = mode_q;
  assign bus.valid     = valid_q;
  assign bus.frameErr  = frame_err;
  assign bus.parityErr = parity_err;
  assign bus.seqErr    = seq_err;
  assign bus.busy      = (state != IDLE);
  assign bus.rejCount  = rej_count;

endmodule

// File: tb/tb_ticket_frame_reader.sv
// Directed bench for ticket_frame_reader: BIT_CYCLES=4 main instance plus a
// BIT_CYCLES=1 instance for the one-bit-per-cycle boundary.
module tb_ticket_frame_reader;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;
  int rej      = 0;

  ticket_frame_reader_if bus0 ();
  ticket_frame_reader_if bus1 ();

  ticket_frame_reader #(.BIT_CYCLES(4)) u0 (.CLK(CLK), .RST(RST), .bus(bus0));
  ticket_frame_reader #(.BIT_CYCLES(1)) u1 (.CLK(CLK), .RST(RST), .bus(bus1));

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one frame on bus0 starting at the next edge (E0) and checks the result
  // appears exactly 28 cycles later. Called back-to-back, E0 is the result cycle edge.
  task automatic frame(input logic [4:0] id, input logic par, input logic stp,
                       input logic g, input logic d, input logic noise,
                       input logic ev, input logic efe, input logic epe, input logic ese);
    logic [6:0] bits;
    bits = {stp, par, id};
    bus0.frameStart = 1'b1;
    bus0.gateIn     = g;
    bus0.dirIn      = d;
    @(posedge CLK); #1;
    bus0.frameStart = 1'b0;
    bus0.gateIn     = ~g;
    bus0.dirIn      = ~d;
    chk("busy after start", 32'(bus0.busy), 32'd1);
    chk("pulses after start",
        32'({bus0.valid, bus0.frameErr, bus0.parityErr, bus0.seqErr}), 32'd0);
    for (int k = 0; k < 7; k++) begin
      bus0.serialIn = bits[k];
      if (noise && k == 2) bus0.frameStart = 1'b1;
      if (noise && k == 3) bus0.frameStart = 1'b0;
      if (k < 6) begin
        repeat (4) @(posedge CLK);
        #1;
      end else begin
        repeat (3) @(posedge CLK);
        #1;
        chk("pulses before stop edge",
            32'({bus0.valid, bus0.frameErr, bus0.parityErr, bus0.seqErr}), 32'd0);
        @(posedge CLK); #1;
      end
    end
    if ((efe || epe || ese) && rej < 255) rej++;
    chk("result pulses",
        32'({bus0.valid, bus0.frameErr, bus0.parityErr, bus0.seqErr}),
        32'({ev, efe, epe, ese}));
    chk("ticketID", 32'(bus0.ticketID), 32'(id));
    chk("gate", 32'(bus0.gate), 32'(g));
    chk("mode", 32'(bus0.mode), 32'(d));
    chk("rejCount", 32'(bus0.rejCount), 32'(rej));
    chk("busy in result cycle", 32'(bus0.busy), 32'd0);
  endtask

  initial begin
    logic       seen;
    logic [6:0] bits1;

    bus0.frameStart = 1'b0; bus0.serialIn = 1'b1; bus0.gateIn = 1'b0; bus0.dirIn = 1'b0;
    bus1.frameStart = 1'b0; bus1.serialIn = 1'b1; bus1.gateIn = 1'b0; bus1.dirIn = 1'b0;

    // reset with serial line toggling
    RST = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
      bus0.serialIn = ~bus0.serialIn;
    end
    chk("reset outputs",
        32'({bus0.ticketID, bus0.gate, bus0.mode, bus0.valid, bus0.frameErr,
             bus0.parityErr, bus0.seqErr, bus0.busy, bus0.rejCount}), 32'd0);
    RST = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge CLK); #1;
      bus0.serialIn = ~bus0.serialIn;
      seen |= bus0.valid | bus0.frameErr | bus0.parityErr | bus0.seqErr | bus0.busy;
    end
    chk("idle no activity", 32'(seen), 32'd0);

    // entry / repeat entry / exit / repeat exit of 0x16
    frame(5'h16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(5'h16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(5'h16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(5'h16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // parity error, then framing error outranking it
    frame(5'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(5'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // mid-frame frameStart noise, then a back-to-back entry
    frame(5'h05, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(5'h0A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset at E0+12 aborts the frame and clears occupancy
    bus0.frameStart = 1'b1;
    bus0.gateIn = 1'b1; bus0.dirIn = 1'b1;
    @(posedge CLK); #1;
    bus0.frameStart = 1'b0;
    bus0.serialIn = 1'b1;
    repeat (11) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("reset mid-frame outputs",
        32'({bus0.ticketID, bus0.gate, bus0.mode, bus0.valid, bus0.frameErr,
             bus0.parityErr, bus0.seqErr, bus0.busy, bus0.rejCount}), 32'd0);
    RST = 1'b0;
    rej = 0;
    seen = 1'b0;
    repeat (35) begin
      @(posedge CLK); #1;
      seen |= bus0.valid | bus0.frameErr | bus0.parityErr | bus0.seqErr | bus0.busy;
    end
    chk("no result after abort", 32'(seen), 32'd0);
    frame(5'h0A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // rejCount saturation
    for (int i = 0; i < 260; i++)
      frame(5'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rejCount saturated", 32'(bus0.rejCount), 32'd255);

    // BIT_CYCLES=1: one bit per cycle, result after 7 cycles
    bits1 = {1'b1, 1'b0, 5'h11};
    bus1.frameStart = 1'b1;
    bus1.gateIn = 1'b0; bus1.dirIn = 1'b1;
    @(posedge CLK); #1;
    bus1.frameStart = 1'b0;
    bus1.gateIn = 1'b1; bus1.dirIn = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus1.serialIn = bits1[k];
      if (k == 0) chk("bc1 busy", 32'(bus1.busy), 32'd1);
      if (k == 6)
        chk("bc1 pulses before stop",
            32'({bus1.valid, bus1.frameErr, bus1.parityErr, bus1.seqErr}), 32'd0);
      @(posedge CLK); #1;
    end
    chk("bc1 result pulses",
        32'({bus1.valid, bus1.frameErr, bus1.parityErr, bus1.seqErr}), 32'b1000);
    chk("bc1 ticketID", 32'(bus1.ticketID), 32'h11);
    chk("bc1 gate/mode", 32'({bus1.gate, bus1.mode}), 32'b01);
    @(posedge CLK); #1;
    chk("bc1 pulse one cycle", 32'(bus1.valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
